// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux_arb_pkg;

    // Width of the burst counter; wide enough for a burst limit of up to 15.
    localparam int CNT_W = 4;

    // Select values exported on SEL.
    localparam logic SEL_IN1 = 1'b0;
    localparam logic SEL_IN2 = 1'b1;

    // IDLE: no recent grant. GNTx: the word most recently accepted came from x.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT1 = 2'd1,
        GNT2 = 2'd2
    } state_t;

    // Increment that sticks at the given ceiling.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                 input logic [CNT_W-1:0] ceil_v);
        return (c >= ceil_v) ? ceil_v : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/mux_arb_grant.sv
// Combinational grant decision for the mux arbiter. Grants depend only on the
// requester VALIDs, the registered FSM state/burst count and whether the
// output register can take a word this cycle.
module mux_arb_grant
    import mux_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic             i_valid1,
    input  logic             i_valid2,
    input  state_t           i_state,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_free,
    output logic             o_grant1,
    output logic             o_grant2
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    logic w_limit;
    assign w_limit = (i_count >= MAX_CNT);

    // Pick at most one requester: lone requester wins, contention goes to the
    // sticky owner until its burst budget is spent, IN1 wins from idle.
    always_comb begin
        o_grant1 = 1'b0;
        o_grant2 = 1'b0;
        if (i_free) begin
            if (i_valid1 && !i_valid2) begin
                o_grant1 = 1'b1;
            end else if (i_valid2 && !i_valid1) begin
                o_grant2 = 1'b1;
            end else if (i_valid1 && i_valid2) begin
                case (i_state)
                    GNT1:    if (w_limit) o_grant2 = 1'b1; else o_grant1 = 1'b1;
                    GNT2:    if (w_limit) o_grant1 = 1'b1; else o_grant2 = 1'b1;
                    default: o_grant1 = 1'b1;
                endcase
            end
        end
    end

endmodule

// File: rtl/mux_2to1_arbiter.sv
// Round-robin 2:1 mux arbiter with sticky, burst-limited grants feeding a
// single registered valid/ready output stage.
// Optional MUX_ARB_STATS_EN adds saturating per-requester accept counters
// on GNT1_CNT / GNT2_CNT.
module mux_2to1_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN1_VALID,
    input  logic [WIDTH-1:0] IN1,
    output logic             IN1_READY,
    input  logic             IN2_VALID,
    input  logic [WIDTH-1:0] IN2,
    output logic             IN2_READY,
    output logic             OUT_VALID,
    output logic [WIDTH-1:0] OUT,
    input  logic             OUT_READY,
    output logic             SEL,
    output logic             BUSY
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [15:0]      GNT1_CNT,
    output logic [15:0]      GNT2_CNT
`endif
);

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_count, w_count_next;
    logic [WIDTH-1:0] r_out, w_out_next;
    logic             r_sel, w_sel_next;
    logic             r_out_valid, w_out_valid_next;

    logic w_free;
    logic w_grant1, w_grant2;
    logic w_acc1, w_acc2;

    // Output register can take a word; nothing is accepted while in reset.
    assign w_free = (!r_out_valid || OUT_READY) && !RST;

    mux_arb_grant #(
        .MAX_BURST (MAX_BURST)
    ) u_grant (
        .i_valid1 (IN1_VALID),
        .i_valid2 (IN2_VALID),
        .i_state  (r_state),
        .i_count  (r_count),
        .i_free   (w_free),
        .o_grant1 (w_grant1),
        .o_grant2 (w_grant2)
    );

    assign IN1_READY = w_grant1;
    assign IN2_READY = w_grant2;
    assign w_acc1    = w_grant1 && IN1_VALID;
    assign w_acc2    = w_grant2 && IN2_VALID;

    assign OUT_VALID = r_out_valid;
    assign OUT       = r_out;
    assign SEL       = r_sel;
    assign BUSY      = r_out_valid || IN1_VALID || IN2_VALID;

    // Next state: load on accept, fall back to idle when free with nothing
    // accepted, and hold everything while the downstream stalls.
    always_comb begin
        w_state_next     = r_state;
        w_count_next     = r_count;
        w_out_next       = r_out;
        w_sel_next       = r_sel;
        w_out_valid_next = r_out_valid;
        if (w_free) begin
            if (w_acc1 || w_acc2) begin
                w_out_next       = w_acc2 ? IN2 : IN1;
                w_sel_next       = w_acc2 ? SEL_IN2 : SEL_IN1;
                w_out_valid_next = 1'b1;
                w_state_next     = w_acc2 ? GNT2 : GNT1;
                w_count_next     = (w_state_next == r_state)
                                 ? sat_inc(r_count, CNT_W'(MAX_BURST))
                                 : {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                w_out_valid_next = 1'b0;
                w_state_next     = IDLE;
                w_count_next     = '0;
            end
        end
    end

    // State and output register; reset drops any held word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_out       <= '0;
            r_sel       <= SEL_IN1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            r_out       <= w_out_next;
            r_sel       <= w_sel_next;
            r_out_valid <= w_out_valid_next;
        end
    end

`ifdef MUX_ARB_STATS_EN
    logic [15:0] r_gnt_cnt [2];
    logic        w_acc [2];

    assign w_acc[0] = w_acc1;
    assign w_acc[1] = w_acc2;
    assign GNT1_CNT = r_gnt_cnt[0];
    assign GNT2_CNT = r_gnt_cnt[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stats
            // Saturating accept counter for one requester.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_gnt_cnt[gi] <= '0;
                end else if (w_acc[gi] && r_gnt_cnt[gi] != 16'hFFFF) begin
                    r_gnt_cnt[gi] <= r_gnt_cnt[gi] + 16'd1;
                end
            end
        end
    endgenerate
`endif

endmodule

// File: doc/mux_2to1_arbiter.md
Name: mux_2to1_arbiter

Overview:
- Round-robin arbiter that shares one 2:1 WIDTH-bit mux datapath and output register between two valid/ready requesters.
- Uses sticky grants with a burst limit and produces a registered output stage with valid/ready handshake.
- Sits in front of any downstream consumer that previously took a statically selected 2:1 mux output.
- Exports the select of the word currently held, so downstream logic can tag its source.

Parameters:
- WIDTH, 8, data width of each requester and of the output.
- MAX_BURST, 4, maximum consecutive grants to one requester while the other is waiting. Legal range 1..15. A value of 1 gives pure alternation.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  synchronous reset, active-high.
- IN1_VALID  input  1  requester 1 has data.
- IN1  input  WIDTH  requester 1 data.
- IN1_READY  output  1  requester 1 word accepted this cycle when IN1_VALID is also high.
- IN2_VALID  input  1  requester 2 has data.
- IN2  input  WIDTH  requester 2 data.
- IN2_READY  output  1  requester 2 word accepted this cycle when IN2_VALID is also high.
- OUT_VALID  output  1  OUT holds a word.
- OUT  output  WIDTH  registered selected data.
- OUT_READY  input  1  downstream accepts OUT this cycle.
- SEL  output  1  source of the word in OUT: 0 = IN1, 1 = IN2.
- BUSY  output  1  high when OUT_VALID is high or either INx_VALID is high.

Behaviour:
- Reset: OUT_VALID=0, OUT=0, SEL=0, FSM=IDLE, burst count=0. IN1_READY and IN2_READY are low during reset.
- Definitions: free = !OUT_VALID || OUT_READY. An accept for requester x occurs when INx_VALID && INx_READY.
- Grant decision is combinational from registered state. At most one READY is high per cycle, and only when free=1.
  - Only one requester valid: grant it.
  - Both valid, FSM=IDLE: grant IN1.
  - Both valid, FSM=GNTx with count<MAX_BURST: grant x (sticky).
  - Both valid, FSM=GNTx with count==MAX_BURST: grant the other requester.
  - Neither valid: no grant.
- READY is independent of the requesters' own VALIDs except through this grant rule. No combinational path from OUT_READY to OUT.
- On accept:
  - OUT<=granted data, SEL<=granted index, OUT_VALID<=1.
  - FSM<=GNT of the granted requester.
  - count<=count+1 if same requester as the previous state, else 1. count saturates at MAX_BURST.
- Latency: accept in cycle N, word on OUT in cycle N+1. Throughput is one word per cycle when OUT_READY is held high.
- free=1 with no accept: OUT_VALID<=0 if OUT_READY was high (drained). FSM<=IDLE and count<=0.
- free=0 (stall): OUT, SEL, OUT_VALID, FSM and count all hold. Both READYs low.
- Simultaneous drain and accept in the same cycle: allowed; OUT is replaced with no bubble.
- RST asserted mid-transfer: the held word is dropped. Everything returns to reset values next edge; no accept occurs in the reset cycle.
- FSM states: IDLE, GNT1, GNT2. Transitions only as described above.

Optional Feature:
- Macro: MUX_ARB_STATS_EN.
- Defined:
  - Adds output ports GNT1_CNT[15:0] and GNT2_CNT[15:0].
  - Each counts accepts for its requester, saturates at 16'hFFFF, and is cleared by RST.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mux_arb_pkg contains:
  - state enum {IDLE, GNT1, GNT2};
  - constants SEL_IN1=1'b0 and SEL_IN2=1'b1;
  - a count-width localparam of 4 bits.
- One natural sub-module, mux_arb_grant: purely combinational grant logic taking the VALIDs, state, count and free, and producing grant1/grant2.
- The data mux and output register stay in the top module.

Test Plan:
- Reset: RST=1 for 2 cycles with both VALIDs high -> both READYs 0. After release, OUT_VALID=0, OUT=0, SEL=0.
- Single requester: IN1_VALID=1, IN1=8'h11, OUT_READY=1 -> IN1_READY=1. Next cycle OUT=8'h11, SEL=0, OUT_VALID=1.
- Burst limit: both valid continuously, IN1=8'hA0+k, IN2=8'hB0+k, MAX_BURST=4, OUT_READY=1 -> SEL sequence on OUT is 0,0,0,0,1,1,1,1,0. No bubbles.
- Backpressure: OUT holds 8'h22 with OUT_READY=0 for 3 cycles -> OUT, SEL and OUT_VALID stable and both READYs 0. Raising OUT_READY drains the word and accepts the next word the same cycle.
- Drain to idle: after an IN2 grant both VALIDs drop -> next cycle OUT_VALID=0 and FSM=IDLE. Then both valid -> IN1 granted first.
- Mid-operation reset, plus MUX_ARB_STATS_EN: 5 IN1 accepts and 3 IN2 accepts -> GNT1_CNT=5, GNT2_CNT=3. Then RST pulse with OUT_VALID=1 -> all outputs and counters 0 next cycle.
